// File: rtl/riscv_wb_pkg.sv
// Shared types and sizes for the writeback arbiter: register address width
// and the per-channel holding slot record.
package riscv_wb_pkg;
  localparam int XLEN       = 32;
  localparam int NPORTS     = 4;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  held;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_slot_t;
endpackage

// File: rtl/riscv_wb_slot.sv
// One completion holding slot: captures an accepted request and releases it
// after the cycle it drains, unless a new request refills it at the same edge.
module riscv_wb_slot
  import riscv_wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       value_i,
  output logic                  ready_o,
  output wb_slot_t              slot_o
);

  wb_slot_t slot_q;
  logic     accept;

  // A full slot can still take a new request when it is draining this cycle.
  assign ready_o = !rst_i && (!slot_q.held || !stall_i);
  assign accept  = valid_i && ready_o;
  assign slot_o  = slot_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q.held <= 1'b0;
    end else if (accept) begin
      slot_q <= '{held: 1'b1, rd: rd_i, value: value_i};
    end else if (!stall_i) begin
      slot_q.held <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: one holding slot per completion channel feeding one
// register-file write port each, with busy tracking, bypass and collision stats.
module riscv_wb_arbiter #(
  parameter int XLEN   = riscv_wb_pkg::XLEN,
  parameter int NPORTS = riscv_wb_pkg::NPORTS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NPORTS-1:0]          cmp_valid_i,
  input  logic [NPORTS-1:0][4:0]     cmp_rd_i,
  input  logic [NPORTS-1:0][XLEN-1:0] cmp_value_i,
  output logic [NPORTS-1:0]          cmp_ready_o,
  input  logic                       stall_i,
  output logic [NPORTS-1:0]          wr_en_o,
  output logic [NPORTS-1:0][4:0]     wr_rd_o,
  output logic [NPORTS-1:0][XLEN-1:0] wr_value_o,
  output logic [31:0]                busy_o,
  input  logic [4:0]                 ra_i,
  input  logic [4:0]                 rb_i,
  output logic                       ra_fwd_valid_o,
  output logic [XLEN-1:0]            ra_fwd_value_o,
  output logic                       rb_fwd_valid_o,
  output logic [XLEN-1:0]            rb_fwd_value_o,
  output logic [15:0]                collisions_o
);
  import riscv_wb_pkg::*;

  wb_slot_t [NPORTS-1:0] slots;
  logic     [7:0]        supp_cnt;
  logic     [16:0]       coll_sum;
  logic                  later_match;

  for (genvar n = 0; n < NPORTS; n++) begin : g_slot
    riscv_wb_slot u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .valid_i (cmp_valid_i[n]),
      .rd_i    (cmp_rd_i[n]),
      .value_i (cmp_value_i[n]),
      .ready_o (cmp_ready_o[n]),
      .slot_o  (slots[n])
    );
    assign wr_rd_o[n]    = slots[n].rd;
    assign wr_value_o[n] = slots[n].value;
  end

  // Same-destination drains: the highest-index slot wins, lower ones are
  // dropped but still released. Nothing is written during a reset cycle.
  always_comb begin
    wr_en_o     = '0;
    supp_cnt    = '0;
    later_match = 1'b0;
    for (int n = 0; n < NPORTS; n++) begin
      later_match = 1'b0;
      for (int m = n + 1; m < NPORTS; m++) begin
        if (slots[m].held && slots[m].rd == slots[n].rd) later_match = 1'b1;
      end
      if (slots[n].held && !stall_i && !rst_i && slots[n].rd != '0) begin
        if (later_match) supp_cnt = supp_cnt + 8'd1;
        else             wr_en_o[n] = 1'b1;
      end
    end
  end

  always_comb begin
    busy_o         = '0;
    ra_fwd_valid_o = 1'b0;
    ra_fwd_value_o = '0;
    rb_fwd_valid_o = 1'b0;
    rb_fwd_value_o = '0;
    // Ascending scan so the highest-index match supplies the forwarded value.
    for (int n = 0; n < NPORTS; n++) begin
      if (slots[n].held && slots[n].rd != '0) begin
        busy_o[slots[n].rd] = 1'b1;
        if (slots[n].rd == ra_i) begin
          ra_fwd_valid_o = 1'b1;
          ra_fwd_value_o = slots[n].value;
        end
        if (slots[n].rd == rb_i) begin
          rb_fwd_valid_o = 1'b1;
          rb_fwd_value_o = slots[n].value;
        end
      end
    end
  end

  assign coll_sum = {1'b0, collisions_o} + {9'd0, supp_cnt};

  always_ff @(posedge clk_i) begin
    if (rst_i)            collisions_o <= '0;
    else if (coll_sum[16]) collisions_o <= 16'hFFFF;
    else                  collisions_o <= coll_sum[15:0];
  end

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of register values.
REQ-002 Parameter NPORTS, default 4, number of completion channels and register-file write ports.
REQ-003 Port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 Ports cmp_valid_i / cmp_rd_i / cmp_value_i, input, NPORTS / NPORTS x 5 / NPORTS x XLEN, completion requests from execution units.
REQ-006 Port cmp_ready_o, input-handshake response, output, NPORTS, channel n accepts when valid and ready are both high at a clock edge.
REQ-007 Port stall_i, input, 1, freezes draining to the register file.
REQ-008 Ports wr_en_o / wr_rd_o / wr_value_o, output, NPORTS / NPORTS x 5 / NPORTS x XLEN, register-file write ports rd0..rd3 plus per-port enable.
REQ-009 Port busy_o, output, 32, bit r set when a held entry targets register r.
REQ-010 Ports ra_i / rb_i, input, 5 each, bypass lookup addresses.
REQ-011 Ports ra_fwd_valid_o / ra_fwd_value_o / rb_fwd_valid_o / rb_fwd_value_o, output, 1 / XLEN / 1 / XLEN, forwarded operands.
REQ-012 Port collisions_o, output, 16, saturating count of suppressed same-destination writes.

Function
REQ-013 Each channel SHALL own one holding slot (held flag, rd, value); an accepted request is captured into the slot at the accepting edge.
REQ-014 Draining: a held slot SHALL drive its write port in every cycle where stall_i is low; the slot is cleared at the end of that cycle unless a new request is accepted at the same edge.
REQ-015 cmp_ready_o[n] SHALL equal (!held_n | !stall_i) and SHALL be 0 while rst_i is high; back-to-back acceptance gives one write per channel per cycle.
REQ-016 Latency: a request accepted at edge k SHALL appear on the write port during cycle k..k+1 and commit in the register file at edge k+1, given stall_i low.
REQ-017 wr_rd_o[n] / wr_value_o[n] SHALL mirror slot n contents; wr_en_o[n] SHALL be held_n & !stall_i & (rd_n != 0) & !suppressed_n.
REQ-018 Slots with rd = 0 SHALL be accepted and drained normally with wr_en_o low; they never affect busy_o or bypass.
REQ-019 Same-destination collision: among slots draining in one cycle with equal nonzero rd, only the highest-index slot asserts wr_en; lower-index slots are suppressed and still cleared.
REQ-020 collisions_o SHALL increase by the number of suppressed slots each cycle, saturating at 16'hFFFF.
REQ-021 Stall: while stall_i is high all wr_en_o SHALL be 0, held slots retain contents, and empty slots may still accept.
REQ-022 busy_o[r] SHALL be the OR over held slots with rd = r, r != 0; busy_o[0] is always 0; this is combinational from slot state.
REQ-023 Bypass: ra_fwd_valid_o SHALL be high when ra_i != 0 and any held slot matches ra_i; the value comes from the highest-index matching slot (rb identical).

Reset
REQ-024 While rst_i is high at an edge, all held flags and collisions_o SHALL be cleared; slot rd/value need not be cleared.
REQ-025 After reset, wr_en_o = 0, busy_o = 0, fwd_valid outputs = 0, and cmp_ready_o = all ones in the first cycle after rst_i falls.
REQ-026 Reset asserted mid-operation SHALL discard held entries without issuing their writes.

Structure
REQ-027 Package riscv_wb_pkg SHALL hold XLEN, NPORTS, REG_ADDR_W = 5, and the slot struct type wb_slot_t (held, rd, value).
REQ-028 One sub-module, riscv_wb_slot, SHALL implement a single holding slot with its accept/drain logic, instantiated NPORTS times.

Verification
REQ-029 Single write: ch0 valid, rd=5, value=32'hDEADBEEF, stall low -> wr_en_o[0]=1 with rd 5 next cycle; busy_o[5]=1 that cycle only.
REQ-030 Collision: ch1 rd=7 value=1 and ch3 rd=7 value=3 in the same cycle -> only wr_en_o[3]=1; collisions_o increments by 1.
REQ-031 Stall: accept ch2 rd=9 and hold stall_i high for 3 cycles -> wr_en_o=0 for 3 cycles, cmp_ready_o[2]=0, ra_i=9 forwards the value; release -> write issues.
REQ-032 x0: ch0 rd=0 value=32'h1234 -> accepted, wr_en_o[0]=0, busy_o=0, ra_i=0 gives ra_fwd_valid_o=0.
REQ-033 Reset mid-stall: a held entry plus a rst_i pulse -> no write issued, busy_o=0, collisions_o=0, all ready high afterwards.
REQ-034 Throughput: ch0 valid continuously for 8 cycles with distinct rd -> 8 consecutive writes, ready never low.
